// File: rtl/hermes_packet_ejector.sv
// Hermes boundary-port ejector: parses header/size/payload from a mesh-edge router port,
// forwards wanted flits to an external sink through a credit-handshaked FIFO, drains oversized packets.
module hermes_packet_ejector #(
  parameter int FLIT_SIZE        = 32,
  parameter int BUFFER_DEPTH     = 8,
  parameter int MAX_PAYLOAD_SIZE = 32,
  parameter int FORWARD_HEADER   = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 noc_rx_i,
  output logic                 noc_credit_o,
  input  logic [FLIT_SIZE-1:0] noc_data_i,
  output logic                 dst_tx_o,
  input  logic                 dst_credit_i,
  output logic [FLIT_SIZE-1:0] dst_data_o,
  output logic [31:0]          pkt_count_o,
  output logic [15:0]          drop_count_o,
  output logic                 busy_o
);

  localparam int AW = $clog2(BUFFER_DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(BUFFER_DEPTH);
  localparam logic [FLIT_SIZE-1:0] MAX_SIZE = FLIT_SIZE'(MAX_PAYLOAD_SIZE);

  typedef enum logic [1:0] {S_HEADER, S_SIZE, S_PAYLOAD, S_DRAIN} state_t;

  state_t               state;
  logic [FLIT_SIZE-1:0] remaining;
  logic [31:0]          pkt_cnt;
  logic [15:0]          drop_cnt;

  logic [FLIT_SIZE-1:0] mem [BUFFER_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          count;

  logic full, empty, accept, push, pop, oversize, last;

  function automatic logic [15:0] sat_inc16(input logic [15:0] x);
    return (x == 16'hFFFF) ? x : x + 16'd1;
  endfunction

  function automatic logic [31:0] wrap_inc32(input logic [31:0] x);
    return x + 32'd1;
  endfunction

  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign oversize = (noc_data_i > MAX_SIZE);
  assign last     = (remaining == FLIT_SIZE'(1));

  // Drain never pushes, so it keeps the router moving even while the sink is stalled.
  assign noc_credit_o = (state == S_DRAIN) || !full;
  assign accept       = noc_rx_i && noc_credit_o;

  always_comb begin
    push = 1'b0;
    if (accept) begin
      case (state)
        S_HEADER:  push = (FORWARD_HEADER != 0);
        S_SIZE:    push = !oversize;
        S_PAYLOAD: push = 1'b1;
        default:   push = 1'b0;
      endcase
    end
  end

  assign dst_tx_o     = !empty;
  assign pop          = !empty && dst_credit_i;
  assign dst_data_o   = mem[rd_ptr];
  assign pkt_count_o  = pkt_cnt;
  assign drop_count_o = drop_cnt;
  assign busy_o       = (state != S_HEADER);

  // FIFO storage: data only, no reset
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= noc_data_i;
  end

  // FIFO control
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Packet parser and counters; advances only on accepted flits
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_HEADER;
      remaining <= '0;
      pkt_cnt   <= '0;
      drop_cnt  <= '0;
    end else if (accept) begin
      case (state)
        S_HEADER: state <= S_SIZE;
        S_SIZE: begin
          remaining <= noc_data_i;
          if (oversize) begin
            drop_cnt <= sat_inc16(drop_cnt);
            state    <= S_DRAIN;
          end else if (noc_data_i == '0) begin
            pkt_cnt <= wrap_inc32(pkt_cnt);
            state   <= S_HEADER;
          end else begin
            state <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          remaining <= remaining - 1'b1;
          if (last) begin
            pkt_cnt <= wrap_inc32(pkt_cnt);
            state   <= S_HEADER;
          end
        end
        S_DRAIN: begin
          remaining <= remaining - 1'b1;
          if (last) state <= S_HEADER;
        end
        default: state <= S_HEADER;
      endcase
    end
  end

endmodule

// File: tb/tb_hermes_packet_ejector.sv
// Directed bench for hermes_packet_ejector: one instance strips headers, a second forwards them.
module tb_hermes_packet_ejector;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx0, rx1;
  logic [31:0] din;
  logic        dst_credit;

  logic        credit0, tx0, busy0;
  logic [31:0] dout0, pkt0;
  logic [15:0] drop0;
  logic        credit1, tx1, busy1;
  logic [31:0] dout1, pkt1;
  logic [15:0] drop1;

  int n_tests = 0;
  int n_fail  = 0;
  int stalls  = 0;
  int accepted = 0;
  int cyc = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int          c0[$];

  hermes_packet_ejector #(.FLIT_SIZE(32), .BUFFER_DEPTH(8), .MAX_PAYLOAD_SIZE(32), .FORWARD_HEADER(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .noc_rx_i(rx0), .noc_credit_o(credit0), .noc_data_i(din),
    .dst_tx_o(tx0), .dst_credit_i(dst_credit), .dst_data_o(dout0),
    .pkt_count_o(pkt0), .drop_count_o(drop0), .busy_o(busy0));

  hermes_packet_ejector #(.FLIT_SIZE(32), .BUFFER_DEPTH(8), .MAX_PAYLOAD_SIZE(32), .FORWARD_HEADER(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .noc_rx_i(rx1), .noc_credit_o(credit1), .noc_data_i(din),
    .dst_tx_o(tx1), .dst_credit_i(dst_credit), .dst_data_o(dout1),
    .pkt_count_o(pkt1), .drop_count_o(drop1), .busy_o(busy1));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Sink monitor: a flit leaves at the next rising edge when tx && credit hold at the falling edge
  always @(negedge clk) begin
    if (!rst) begin
      if (tx0 && dst_credit) begin
        q0.push_back(dout0);
        c0.push_back(cyc);
      end
      if (tx1 && dst_credit) q1.push_back(dout1);
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  task automatic send(input int sel, input logic [31:0] d);
    bit acc = 1'b0;
    int waited = 0;
    if (sel == 0) rx0 = 1'b1; else rx1 = 1'b1;
    din = d;
    while (!acc && waited < 200) begin
      @(negedge clk);
      acc = (sel == 0) ? credit0 : credit1;
      if (!acc) stalls++;
      @(posedge clk);
      #1;
      waited++;
    end
    rx0 = 1'b0;
    rx1 = 1'b0;
    if (!acc) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout flit=%h not accepted within 200 cycles", d);
    end else accepted++;
  endtask

  task automatic send_pkt(input int sel, input logic [31:0] hdr, input int size, input logic [31:0] base);
    send(sel, hdr);
    send(sel, size);
    for (int i = 0; i < size; i++) send(sel, base + i);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; rx0 = 1'b0; rx1 = 1'b0; din = '0; dst_credit = 1'b1;
    idle(2);
    rst = 1'b0;
    q0.delete(); q1.delete(); c0.delete();
    stalls = 0; accepted = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({tx0, credit0, busy0} !== 3'b010 || pkt0 !== 32'd0 || drop0 !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_state tx/credit/busy=%b pkt=%0d drop=%0d, required 010 0 0",
               {tx0, credit0, busy0}, pkt0, drop0);
    end
  endtask

  task automatic test_strip_header();
    logic [31:0] exp [4] = '{32'd3, 32'hA, 32'hB, 32'hC};
    do_reset();
    send(0, 32'h0102);
    n_tests++;
    if (busy0 !== 1'b1) begin n_fail++; $display("FAIL busy_after_header got %b required 1", busy0); end
    send(0, 32'd3); send(0, 32'hA); send(0, 32'hB); send(0, 32'hC);
    idle(5);
    n_tests++;
    if (q0.size() !== 4) begin
      n_fail++; $display("FAIL strip_count got %0d flits required 4", q0.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (q0[i] !== exp[i]) begin n_fail++; $display("FAIL strip_data[%0d] got %h required %h", i, q0[i], exp[i]); end
      end
      n_tests++;
      if (c0[3] - c0[0] !== 3) begin n_fail++; $display("FAIL strip_consecutive span %0d cycles required 3", c0[3] - c0[0]); end
    end
    n_tests++;
    if (pkt0 !== 32'd1) begin n_fail++; $display("FAIL strip_pkt_count got %0d required 1", pkt0); end
  endtask

  task automatic test_forward_header_zero_size();
    do_reset();
    send(1, 32'h0203); send(1, 32'd0);
    idle(4);
    n_tests++;
    if (q1.size() !== 2 || q1[0] !== 32'h0203 || q1[1] !== 32'd0) begin
      n_fail++; $display("FAIL fwd_hdr_data got %0d flits (first %h) required 0203,0", q1.size(), q1.size() > 0 ? q1[0] : 32'hx);
    end
    n_tests++;
    if (pkt1 !== 32'd1 || busy1 !== 1'b0) begin
      n_fail++; $display("FAIL fwd_hdr_state pkt=%0d busy=%b required 1 0", pkt1, busy1);
    end
  endtask

  task automatic test_max_size();
    do_reset();
    send_pkt(0, 32'h0101, 32, 32'h1000);
    idle(4);
    n_tests++;
    if (q0.size() !== 33 || q0[0] !== 32'd32 || q0[32] !== 32'h101F) begin
      n_fail++; $display("FAIL max_size got %0d flits required 33 ending 101f", q0.size());
    end
    n_tests++;
    if (pkt0 !== 32'd1 || drop0 !== 16'd0) begin
      n_fail++; $display("FAIL max_size_counts pkt=%0d drop=%0d required 1 0", pkt0, drop0);
    end
  endtask

  task automatic test_oversize_drop();
    do_reset();
    send_pkt(0, 32'h0300, 33, 32'h2000);
    idle(3);
    n_tests++;
    if (q0.size() !== 0 || stalls !== 0) begin
      n_fail++; $display("FAIL drop_silent forwarded=%0d stalls=%0d required 0 0", q0.size(), stalls);
    end
    n_tests++;
    if (drop0 !== 16'd1 || pkt0 !== 32'd0 || busy0 !== 1'b0) begin
      n_fail++; $display("FAIL drop_counts drop=%0d pkt=%0d busy=%b required 1 0 0", drop0, pkt0, busy0);
    end
    send_pkt(0, 32'h0301, 1, 32'h55);
    idle(3);
    n_tests++;
    if (q0.size() !== 2 || q0[0] !== 32'd1 || q0[1] !== 32'h55 || pkt0 !== 32'd1) begin
      n_fail++; $display("FAIL after_drop flits=%0d pkt=%0d required 2 (1,55) 1", q0.size(), pkt0);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp [5] = '{32'd1, 32'h77, 32'd2, 32'h88, 32'h89};
    do_reset();
    send_pkt(0, 32'h0401, 1, 32'h77);
    send_pkt(0, 32'h0402, 2, 32'h88);
    idle(5);
    n_tests++;
    if (stalls !== 0 || accepted !== 7 || q0.size() !== 5) begin
      n_fail++; $display("FAIL b2b_flow stalls=%0d accepted=%0d flits=%0d required 0 7 5", stalls, accepted, q0.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_tests++;
        if (q0[i] !== exp[i]) begin n_fail++; $display("FAIL b2b_data[%0d] got %h required %h", i, q0[i], exp[i]); end
      end
    end
    n_tests++;
    if (pkt0 !== 32'd2) begin n_fail++; $display("FAIL b2b_pkt_count got %0d required 2", pkt0); end
  endtask

  task automatic test_backpressure();
    do_reset();
    dst_credit = 1'b0;
    fork
      send_pkt(0, 32'h0500, 11, 32'h3000);
      begin
        int w = 0;
        @(negedge clk);
        while (credit0 && w < 60) begin @(negedge clk); w++; end
        n_tests++;
        if (credit0 !== 1'b0 || accepted !== 9) begin
          n_fail++; $display("FAIL bp_credit_drop credit=%b accepted=%0d required 0 9", credit0, accepted);
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if (tx0 !== 1'b1 || dout0 !== 32'd11 || credit0 !== 1'b0) begin
          n_fail++; $display("FAIL bp_hold tx=%b head=%h credit=%b required 1 0000000b 0", tx0, dout0, credit0);
        end
        @(posedge clk); #1;
        dst_credit = 1'b1;
      end
    join
    idle(20);
    n_tests++;
    if (q0.size() !== 12) begin
      n_fail++; $display("FAIL bp_count got %0d flits required 12", q0.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        n_tests++;
        if (q0[i] !== ((i == 0) ? 32'd11 : 32'h3000 + i - 1)) begin
          n_fail++; $display("FAIL bp_data[%0d] got %h", i, q0[i]);
        end
      end
    end
    n_tests++;
    if (pkt0 !== 32'd1) begin n_fail++; $display("FAIL bp_pkt_count got %0d required 1", pkt0); end
  endtask

  task automatic test_mid_packet_reset();
    do_reset();
    dst_credit = 1'b0;
    send_pkt(0, 32'h0600, 0, 32'h0);
    send(0, 32'h0601); send(0, 32'd5); send(0, 32'h4000); send(0, 32'h4001);
    n_tests++;
    if (tx0 !== 1'b1 || pkt0 !== 32'd1 || busy0 !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset tx=%b pkt=%0d busy=%b required 1 1 1", tx0, pkt0, busy0);
    end
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    n_tests++;
    if ({tx0, credit0, busy0} !== 3'b010 || pkt0 !== 32'd0 || drop0 !== 16'd0) begin
      n_fail++; $display("FAIL mid_reset tx/credit/busy=%b pkt=%0d drop=%0d required 010 0 0",
                         {tx0, credit0, busy0}, pkt0, drop0);
    end
    q0.delete();
    dst_credit = 1'b1;
    send_pkt(0, 32'h4002, 1, 32'h99);
    idle(3);
    n_tests++;
    if (q0.size() !== 2 || q0[0] !== 32'd1 || q0[1] !== 32'h99 || pkt0 !== 32'd1) begin
      n_fail++; $display("FAIL post_reset_parse flits=%0d pkt=%0d required 2 (1,99) 1", q0.size(), pkt0);
    end
  endtask

  task automatic test_drop_saturation();
    do_reset();
    force dut0.drop_cnt = 16'hFFFE;
    idle(1);
    release dut0.drop_cnt;
    idle(1);
    n_tests++;
    if (drop0 !== 16'hFFFE) begin n_fail++; $display("FAIL drop_preset got %h required fffe", drop0); end
    send_pkt(0, 32'h0700, 33, 32'h0);
    idle(1);
    n_tests++;
    if (drop0 !== 16'hFFFF) begin n_fail++; $display("FAIL drop_reach_max got %h required ffff", drop0); end
    send_pkt(0, 32'h0701, 40, 32'h0);
    idle(1);
    n_tests++;
    if (drop0 !== 16'hFFFF || q0.size() !== 0) begin
      n_fail++; $display("FAIL drop_saturate got %h flits=%0d required ffff 0", drop0, q0.size());
    end
  endtask

  initial begin
    rst = 1'b1; rx0 = 1'b0; rx1 = 1'b0; din = '0; dst_credit = 1'b1;
    test_reset();
    test_strip_header();
    test_forward_header_zero_size();
    test_max_size();
    test_oversize_drop();
    test_back_to_back();
    test_backpressure();
    test_mid_packet_reset();
    test_drop_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
